// File: rtl/hex_scroller_if.sv
`default_nettype none
// hex_scroller_if: character memory read port (address out, data back one cycle later).
// Revision 1.0
interface hex_scroller_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (output mem_addr, input mem_data);
  modport slave  (input mem_addr, output mem_data);
endinterface
`default_nettype wire

// File: rtl/hex_scroller.sv
`default_nettype none
// hex_scroller: NUM_DIGITS-wide scrolling window over a MSG_LEN-character message, driving active-low HEX digits.
// Revision 1.0
module hex_scroller #(
  parameter int NUM_DIGITS = 6,
  parameter int ADDR_W     = 5,
  parameter int MSG_LEN    = 32,
  parameter int TICK_DIV   = 25000000
) (
  input  wire logic                    Clock,
  input  wire logic                    Resetn,
  input  wire logic                    Step,
  input  wire logic                    Mode,
  input  wire logic                    Dir,
  hex_scroller_if.master               mem,
  output logic [7*NUM_DIGITS-1:0]      HEX,
  output logic [ADDR_W-1:0]            Base,
  output logic                         Busy
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0]  c_TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  c_LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_IDLE   = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [1:0]              sync_q;
  logic                    step_prev_q;
  logic [CNT_W-1:0]        tick_q, tick_d;
  logic                    pend_q, pend_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    cap_q;
  logic [7*NUM_DIGITS-1:0] stage_q, stage_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    busy_q;

  logic                    w_fetch, w_commit, w_idle;
  logic                    w_req_step, w_req_tick, w_req, w_adv;
  logic [6:0]              w_seg;
  logic [7*NUM_DIGITS-1:0] w_shifted;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == c_LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_dec(input logic [ADDR_W-1:0] a);
    return (a == '0) ? c_LAST_ADDR : a - ADDR_W'(1);
  endfunction

  // Segment order is g..a, active-low; anything unlisted is blank.
  function automatic logic [6:0] seg_decode(input logic [7:0] ch);
    case (ch)
      8'd65:   return 7'b0001000;
      8'd98:   return 7'b0000011;
      8'd67:   return 7'b1000110;
      8'd100:  return 7'b0100001;
      8'd69:   return 7'b0000110;
      8'd70:   return 7'b0001110;
      8'd103:  return 7'b0010000;
      8'd104:  return 7'b0001011;
      8'd48:   return 7'b1000000;
      8'd49:   return 7'b1111001;
      8'd50:   return 7'b0100100;
      8'd51:   return 7'b0110000;
      8'd52:   return 7'b0011001;
      8'd53:   return 7'b0010010;
      8'd54:   return 7'b0000010;
      8'd55:   return 7'b1111000;
      8'd56:   return 7'b0000000;
      8'd57:   return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign w_seg = seg_decode(mem.mem_data);

  generate
    if (NUM_DIGITS == 1) begin : g_shift_single
      assign w_shifted = w_seg;
    end else begin : g_shift_multi
      assign w_shifted = {stage_q[7*NUM_DIGITS-8:0], w_seg};
    end
  endgenerate

  assign w_req_step = sync_q[1] & ~step_prev_q & ~Mode;
  assign w_req_tick = Mode & w_idle & (tick_q == c_TICK_LAST);
  assign w_req      = w_req_step | w_req_tick;
  assign w_adv      = w_idle & (w_req | pend_q);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  if (idx_q == c_LAST_IDX) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      S_IDLE:   if (w_adv) state_d = S_FETCH;
      default:  state_d = S_INIT;
    endcase
  end

  always_comb begin
    w_fetch  = 1'b0;
    w_commit = 1'b0;
    w_idle   = 1'b0;
    case (state_q)
      S_FETCH:  w_fetch  = 1'b1;
      S_COMMIT: w_commit = 1'b1;
      S_IDLE:   w_idle   = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    tick_d  = tick_q;
    pend_d  = pend_q;
    base_d  = base_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    hex_d   = hex_q;

    // The tick only advances while idle, so fetch time stretches the scroll period.
    if (!Mode) begin
      tick_d = '0;
    end else if (w_idle) begin
      tick_d = (tick_q == c_TICK_LAST) ? '0 : tick_q + CNT_W'(1);
    end

    if (w_adv) begin
      base_d = Dir ? addr_dec(base_q) : addr_inc(base_q);
      addr_d = base_d;
      idx_d  = '0;
      pend_d = 1'b0;
    end else if (w_req && !w_idle) begin
      pend_d = 1'b1;
    end

    if (w_fetch) begin
      if (idx_q == c_LAST_IDX) begin
        addr_d = base_q;
        idx_d  = '0;
      end else begin
        addr_d = addr_inc(addr_q);
        idx_d  = idx_q + IDX_W'(1);
      end
    end

    if (cap_q) begin
      stage_d = w_shifted;
    end

    if (w_commit) begin
      hex_d = stage_q;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync_q      <= 2'b11;
      step_prev_q <= 1'b1;
      tick_q      <= '0;
      pend_q      <= 1'b0;
      base_q      <= '0;
      addr_q      <= '0;
      idx_q       <= '0;
      cap_q       <= 1'b0;
      stage_q     <= '1;
      hex_q       <= '1;
      busy_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], Step};
      step_prev_q <= sync_q[1];
      tick_q      <= tick_d;
      pend_q      <= pend_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      cap_q       <= w_fetch;
      stage_q     <= stage_d;
      hex_q       <= hex_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign mem.mem_addr = addr_q;
  assign HEX          = hex_q;
  assign Base         = base_q;
  assign Busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_scroller.sv
`default_nettype none
// tb_hex_scroller: randomized self-checking bench for hex_scroller against a window/decode reference model.
// Revision 1.0
module tb_hex_scroller;

  localparam int N  = 6;
  localparam int AW = 5;
  localparam int ML = 32;
  localparam int TD = 4;

  localparam byte unsigned c_LET_CODE [8] = '{8'd65, 8'd98, 8'd67, 8'd100, 8'd69, 8'd70, 8'd103, 8'd104};
  localparam logic [6:0]   c_LET_SEG  [8] = '{7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001,
                                              7'b0000110, 7'b0001110, 7'b0010000, 7'b0001011};
  localparam logic [6:0]   c_DIG_SEG  [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam byte unsigned c_POOL [12] = '{8'd65, 8'd98, 8'd67, 8'd100, 8'd69, 8'd70,
                                           8'd103, 8'd104, 8'd32, 8'd120, 8'd97, 8'd72};

  logic            Clock  = 1'b0;
  logic            Resetn = 1'b0;
  logic            Step   = 1'b0;
  logic            Mode   = 1'b0;
  logic            Dir    = 1'b0;
  logic [7*N-1:0]  HEX;
  logic [AW-1:0]   Base;
  logic            Busy;

  hex_scroller_if #(.ADDR_W(AW)) mif ();

  hex_scroller #(.NUM_DIGITS(N), .ADDR_W(AW), .MSG_LEN(ML), .TICK_DIV(TD)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Step   (Step),
    .Mode   (Mode),
    .Dir    (Dir),
    .mem    (mif),
    .HEX    (HEX),
    .Base   (Base),
    .Busy   (Busy)
  );

  always #5 Clock = ~Clock;

  byte unsigned mem_arr [ML];
  always @(posedge Clock) mif.mem_data <= mem_arr[mif.mem_addr];

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int m_base   = 0;
  int addr_q [$];

  function automatic logic [6:0] seg_of(input byte unsigned c);
    for (int i = 0; i < 8; i++) if (c == c_LET_CODE[i]) return c_LET_SEG[i];
    if (c >= 8'd48 && c <= 8'd57) return c_DIG_SEG[c - 8'd48];
    return 7'b1111111;
  endfunction

  function automatic logic [7*N-1:0] exp_hex(input int b);
    logic [7*N-1:0] r;
    for (int i = 0; i < N; i++) r[7*(N-1-i) +: 7] = seg_of(mem_arr[(b + i) % ML]);
    return r;
  endfunction

  // Waits for a fetch to begin, then counts busy cycles and records the addresses seen.
  task automatic fetch_window(output int nbusy, output bit to);
    int w;
    nbusy = 0;
    to    = 1'b0;
    w     = 0;
    addr_q.delete();
    @(negedge Clock);
    while (!Busy && w < 30) begin
      @(negedge Clock);
      w++;
    end
    if (!Busy) begin
      to = 1'b1;
      return;
    end
    while (Busy && nbusy < 40) begin
      addr_q.push_back(int'(mif.mem_addr));
      nbusy++;
      @(negedge Clock);
    end
    if (Busy) to = 1'b1;
  endtask

  task automatic test_reset();
    int nb;
    bit to;
    int got;
    string s;
    s = "AbCdEFgh0123456789he  Fab 42 Cd8";
    for (int i = 0; i < ML; i++) mem_arr[i] = s[i];
    Resetn = 1'b0;
    repeat (3) @(negedge Clock);
    n_checks++; if (HEX !== '1) begin n_fail++; $display("FAIL reset_hex: got %h want all ones", HEX); end
    n_checks++; if (Base !== '0) begin n_fail++; $display("FAIL reset_base: got %0d want 0", Base); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_checks++; if (mif.mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", mif.mem_addr); end
    Resetn = 1'b1;
    m_base = 0;
    fetch_window(nb, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL init_timeout: got %b want 0", to); end
    n_checks++; if (nb !== 8) begin n_fail++; $display("FAIL init_busy_cycles: got %0d want 8", nb); end
    for (int i = 0; i < N; i++) begin
      got = (i < addr_q.size()) ? addr_q[i] : -1;
      n_checks++; if (got !== i) begin n_fail++; $display("FAIL init_addr[%0d]: got %0d want %0d", i, got, i); end
    end
    n_checks++; if (HEX !== exp_hex(0)) begin n_fail++; $display("FAIL init_hex: got %h want %h", HEX, exp_hex(0)); end
    n_checks++; if (Base !== AW'(0)) begin n_fail++; $display("FAIL init_base: got %0d want 0", Base); end
  endtask

  task automatic test_manual_step();
    int nb;
    int extra;
    bit to;
    Mode = 1'b0;
    Dir  = 1'b0;
    Step = 1'b1;
    fetch_window(nb, to);
    m_base = (m_base + 1) % ML;
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL step_timeout: got %b want 0", to); end
    n_checks++; if (nb !== 8) begin n_fail++; $display("FAIL step_latency: got %0d want 8", nb); end
    n_checks++; if (HEX !== exp_hex(m_base)) begin n_fail++; $display("FAIL step_hex: got %h want %h", HEX, exp_hex(m_base)); end
    extra = 0;
    repeat (85) begin
      @(negedge Clock);
      if (Busy) extra++;
    end
    Step = 1'b0;
    repeat (5) @(negedge Clock);
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL step_held_refire: got %0d busy cycles want 0", extra); end
    n_checks++; if (Base !== AW'(m_base)) begin n_fail++; $display("FAIL step_base: got %0d want %0d", Base, m_base); end
  endtask

  task automatic test_dir_down();
    int nb;
    int got;
    int want;
    bit to;
    Dir = 1'b1;
    for (int k = 0; k < 2; k++) begin
      Step = 1'b1;
      fetch_window(nb, to);
      Step = 1'b0;
      m_base = (m_base + ML - 1) % ML;
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL down_timeout: got %b want 0", to); end
      n_checks++; if (Base !== AW'(m_base)) begin n_fail++; $display("FAIL down_base: got %0d want %0d", Base, m_base); end
      n_checks++; if (HEX !== exp_hex(m_base)) begin n_fail++; $display("FAIL down_hex: got %h want %h", HEX, exp_hex(m_base)); end
      repeat (4) @(negedge Clock);
    end
    for (int i = 0; i < N; i++) begin
      got  = (i < addr_q.size()) ? addr_q[i] : -1;
      want = (m_base + i) % ML;
      n_checks++; if (got !== want) begin n_fail++; $display("FAIL down_addr[%0d]: got %0d want %0d", i, got, want); end
    end
  endtask

  task automatic test_random_steps();
    int nb;
    bit to;
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < 6; j++)
        mem_arr[$urandom_range(ML - 1, 0)] = ($urandom_range(2, 0) == 0) ?
            8'($urandom_range(57, 48)) : c_POOL[$urandom_range(11, 0)];
      Dir  = 1'($urandom_range(1, 0));
      Step = 1'b1;
      fetch_window(nb, to);
      Step = 1'b0;
      m_base = Dir ? (m_base + ML - 1) % ML : (m_base + 1) % ML;
      n_checks++; if (nb !== 8) begin n_fail++; $display("FAIL rand_busy[%0d]: got %0d want 8", k, nb); end
      n_checks++; if (Base !== AW'(m_base)) begin n_fail++; $display("FAIL rand_base[%0d]: got %0d want %0d", k, Base, m_base); end
      n_checks++; if (HEX !== exp_hex(m_base)) begin n_fail++; $display("FAIL rand_hex[%0d]: got %h want %h", k, HEX, exp_hex(m_base)); end
      repeat ($urandom_range(6, 3)) @(negedge Clock);
    end
  endtask

  task automatic test_auto_scroll();
    int w;
    int prev_cyc;
    int old_base;
    int stable;
    Dir      = 1'b0;
    Mode     = 1'b1;
    prev_cyc = 0;
    for (int k = 0; k < 34; k++) begin
      w = 0;
      while (Base === AW'(m_base) && w < 30) begin
        @(negedge Clock);
        w++;
      end
      old_base = m_base;
      m_base   = (m_base + 1) % ML;
      n_checks++; if (Base !== AW'(m_base)) begin n_fail++; $display("FAIL auto_base[%0d]: got %0d want %0d", k, Base, m_base); end
      if (k > 0) begin
        n_checks++; if (cyc - prev_cyc !== TD + 8) begin n_fail++; $display("FAIL auto_period[%0d]: got %0d want %0d", k, cyc - prev_cyc, TD + 8); end
        n_checks++; if (HEX !== exp_hex(old_base)) begin n_fail++; $display("FAIL auto_hex[%0d]: got %h want %h", k, HEX, exp_hex(old_base)); end
      end
      prev_cyc = cyc;
      if (k == 33) Mode = 1'b0;
    end
    w = 0;
    while (Busy && w < 30) begin
      @(negedge Clock);
      w++;
    end
    n_checks++; if (HEX !== exp_hex(m_base)) begin n_fail++; $display("FAIL auto_final_hex: got %h want %h", HEX, exp_hex(m_base)); end
    stable = 0;
    repeat (30) begin
      @(negedge Clock);
      if (Base !== AW'(m_base)) stable++;
    end
    n_checks++; if (stable !== 0) begin n_fail++; $display("FAIL auto_stop: got %0d moved cycles want 0", stable); end
  endtask

  task automatic test_back_to_back();
    int changes;
    int busy_n;
    int first_b;
    int last_b;
    logic [AW-1:0] seen;
    Mode    = 1'b0;
    Dir     = 1'b0;
    changes = 0;
    busy_n  = 0;
    first_b = -1;
    last_b  = -1;
    seen    = Base;
    for (int k = 0; k < 40; k++) begin
      if (Base !== seen) changes++;
      seen = Base;
      if (Busy) begin
        busy_n++;
        if (first_b < 0) first_b = k;
        last_b = k;
      end
      Step = (k < 8) && (k % 3 != 2);
      @(negedge Clock);
    end
    m_base = (m_base + 2) % ML;
    n_checks++; if (changes !== 2) begin n_fail++; $display("FAIL b2b_advances: got %0d want 2", changes); end
    n_checks++; if (busy_n !== 16) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want 16", busy_n); end
    n_checks++; if (last_b - first_b !== 16) begin n_fail++; $display("FAIL b2b_gap: got span %0d want 16", last_b - first_b); end
    n_checks++; if (Base !== AW'(m_base)) begin n_fail++; $display("FAIL b2b_base: got %0d want %0d", Base, m_base); end
    n_checks++; if (HEX !== exp_hex(m_base)) begin n_fail++; $display("FAIL b2b_hex: got %h want %h", HEX, exp_hex(m_base)); end
  endtask

  task automatic test_reset_midfetch();
    int nb;
    int w;
    bit to;
    Dir  = 1'b0;
    Step = 1'b1;
    w    = 0;
    while (!Busy && w < 30) begin
      @(negedge Clock);
      w++;
    end
    repeat (3) @(negedge Clock);
    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL midfetch_busy: got %b want 1", Busy); end
    Step   = 1'b0;
    Resetn = 1'b0;
    #1;
    n_checks++; if (HEX !== '1) begin n_fail++; $display("FAIL midfetch_hex_blank: got %h want all ones", HEX); end
    n_checks++; if (Base !== '0) begin n_fail++; $display("FAIL midfetch_base: got %0d want 0", Base); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL midfetch_busy_clr: got %b want 0", Busy); end
    m_base = 0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    fetch_window(nb, to);
    n_checks++; if (nb !== 8) begin n_fail++; $display("FAIL refill_busy: got %0d want 8", nb); end
    n_checks++; if (HEX !== exp_hex(0)) begin n_fail++; $display("FAIL refill_hex: got %h want %h", HEX, exp_hex(0)); end
    n_checks++; if (Base !== AW'(0)) begin n_fail++; $display("FAIL refill_base: got %0d want 0", Base); end
  endtask

  initial begin
    test_reset();
    test_manual_step();
    test_dir_down();
    test_random_steps();
    test_auto_scroll();
    test_back_to_back();
    test_reset_midfetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
